// File: rtl/parity_serial_rx.sv
// Serial frame receiver (start, DATA_W bits LSB first, XOR parity, stop) with a one-word valid/ready buffer.
// Latency: data_valid rises one cycle after the mid-stop-bit sample; PARITY_RX_SYNC_EN adds a 2-flop rx synchronizer (+2 cycles).
// Backpressure: a frame finishing while the buffer is full and not being accepted is dropped and sets sticky overrun.
module parity_serial_rx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic             PAR_ODD  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [DATA_W-1:0] shift, shift_nxt;
  logic              par_bit, par_nxt;
  logic              frame_done;
  logic              bit_tick;
  logic              rx_s;

`ifdef PARITY_RX_SYNC_EN
  logic [1:0] rx_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_sync <= 2'b11;
    else        rx_sync <= {rx_sync[0], rx};
  end

  assign rx_s = rx_sync[1];
`else
  assign rx_s = rx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      shift   <= shift_nxt;
      par_bit <= par_nxt;
    end
  end

  assign bit_tick = (cnt == FULL_M1);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    idx_nxt    = idx;
    shift_nxt  = shift;
    par_nxt    = par_bit;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      START: begin
        // Re-check the line at mid start bit to reject glitches.
        if (cnt == HALF_M1) begin
          cnt_nxt = '0;
          if (rx_s) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = DATA;
            idx_nxt   = '0;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_tick) begin
          cnt_nxt   = '0;
          // Shift in at the MSB so the first (LSB) bit ends up in bit 0.
          shift_nxt = (shift >> 1) | (DATA_W'(rx_s) << (DATA_W - 1));
          if (idx == LAST_IDX) state_nxt = PARITY;
          else                 idx_nxt   = idx + IDX_W'(1);
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      PARITY: begin
        if (bit_tick) begin
          cnt_nxt   = '0;
          par_nxt   = rx_s;
          state_nxt = STOP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_tick) begin
          cnt_nxt    = '0;
          frame_done = 1'b1;
          state_nxt  = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data       <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (frame_done) begin
      if (!data_valid || data_ready) begin
        data       <= shift;
        parity_err <= (^shift) ^ par_bit ^ PAR_ODD;
        frame_err  <= ~rx_s;
        data_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (data_valid && data_ready) begin
      data_valid <= 1'b0;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_parity_serial_rx.sv
// Directed bench for parity_serial_rx: even-parity DUT plus an odd-parity DUT on the same line.
module tb_parity_serial_rx;

  localparam int DW  = 8;
  localparam int CPB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic          data_ready = 1'b1;
  logic [DW-1:0] data, data_o;
  logic          data_valid, data_valid_o;
  logic          parity_err, parity_err_o;
  logic          frame_err, frame_err_o;
  logic          overrun, overrun_o;
  logic          busy, busy_o;

  int n_checks = 0;
  int n_errors = 0;

  int            acc_cnt = 0;
  logic [DW-1:0] acc_data = '0;
  logic          acc_perr = 1'b0;
  logic          acc_ferr = 1'b0;
  logic          acc_perr_o = 1'b0;
  logic          busy_seen = 1'b0;

  parity_serial_rx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_ODD(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data(data), .data_valid(data_valid),
    .data_ready(data_ready), .parity_err(parity_err), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
  );

  parity_serial_rx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_ODD(1)) u_dut_odd (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data(data_o), .data_valid(data_valid_o),
    .data_ready(data_ready), .parity_err(parity_err_o), .frame_err(frame_err_o),
    .overrun(overrun_o), .busy(busy_o)
  );

  always #5 clk = ~clk;

  // Record every handshake the DUT will complete on the coming rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_seen = 1'b1;
      if (data_valid && data_ready) begin
        acc_cnt  = acc_cnt + 1;
        acc_data = data;
        acc_perr = parity_err;
        acc_ferr = frame_err;
      end
      if (data_valid_o && data_ready) acc_perr_o = parity_err_o;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic hold_bit();
    repeat (CPB) tick();
  endtask

  task automatic clear_mon();
    acc_cnt    = 0;
    acc_data   = '0;
    acc_perr   = 1'b0;
    acc_ferr   = 1'b0;
    acc_perr_o = 1'b0;
    busy_seen  = 1'b0;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic par, input logic stop);
    rx = 1'b0;
    hold_bit();
    for (int i = 0; i < DW; i++) begin
      rx = d[i];
      hold_bit();
    end
    rx = par;
    hold_bit();
    rx = stop;
    hold_bit();
    rx = 1'b1;
    repeat (2 * CPB) tick();
  endtask

  initial begin
    repeat (3) tick();
    check_eq("rst_data", 32'(data), 32'h0);
    check_eq("rst_valid", 32'(data_valid), 32'h0);
    check_eq("rst_perr", 32'(parity_err), 32'h0);
    check_eq("rst_ferr", 32'(frame_err), 32'h0);
    check_eq("rst_overrun", 32'(overrun), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Clean 0xA5, even parity bit 0; the odd-parity receiver flags it.
    clear_mon();
    send_frame(8'hA5, 1'b0, 1'b1);
    check_eq("a5_count", 32'(acc_cnt), 32'd1);
    check_eq("a5_data", 32'(acc_data), 32'hA5);
    check_eq("a5_perr", 32'(acc_perr), 32'h0);
    check_eq("a5_ferr", 32'(acc_ferr), 32'h0);
    check_eq("a5_odd_perr", 32'(acc_perr_o), 32'h1);

    // 0xA5 with parity 1: even flags it, odd accepts it.
    clear_mon();
    send_frame(8'hA5, 1'b1, 1'b1);
    check_eq("a5p1_count", 32'(acc_cnt), 32'd1);
    check_eq("a5p1_data", 32'(acc_data), 32'hA5);
    check_eq("a5p1_perr", 32'(acc_perr), 32'h1);
    check_eq("a5p1_ferr", 32'(acc_ferr), 32'h0);
    check_eq("a5p1_odd_perr", 32'(acc_perr_o), 32'h0);

    // 0x3C with a bad stop bit, then a clean 0x01.
    clear_mon();
    send_frame(8'h3C, 1'b0, 1'b0);
    check_eq("3c_count", 32'(acc_cnt), 32'd1);
    check_eq("3c_data", 32'(acc_data), 32'h3C);
    check_eq("3c_ferr", 32'(acc_ferr), 32'h1);
    check_eq("3c_perr", 32'(acc_perr), 32'h0);
    repeat (4) tick();
    clear_mon();
    send_frame(8'h01, 1'b1, 1'b1);
    check_eq("01_count", 32'(acc_cnt), 32'd1);
    check_eq("01_data", 32'(acc_data), 32'h01);
    check_eq("01_perr", 32'(acc_perr), 32'h0);
    check_eq("01_ferr", 32'(acc_ferr), 32'h0);

    // One-cycle low glitch: false start.
    clear_mon();
    rx = 1'b0;
    tick();
    rx = 1'b1;
    repeat (12) tick();
    check_eq("glitch_busy_seen", 32'(busy_seen), 32'h1);
    check_eq("glitch_count", 32'(acc_cnt), 32'd0);
    check_eq("glitch_busy_end", 32'(busy), 32'h0);

    // Overrun: buffer holds 0x11, 0x22 is dropped.
    clear_mon();
    data_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    check_eq("ovr_data", 32'(data), 32'h11);
    check_eq("ovr_valid", 32'(data_valid), 32'h1);
    check_eq("ovr_flag", 32'(overrun), 32'h1);
    check_eq("ovr_no_accept", 32'(acc_cnt), 32'd0);
    data_ready = 1'b1;
    repeat (3) tick();
    check_eq("ovr_accept_count", 32'(acc_cnt), 32'd1);
    check_eq("ovr_accept_data", 32'(acc_data), 32'h11);
    check_eq("ovr_valid_low", 32'(data_valid), 32'h0);
    check_eq("ovr_sticky", 32'(overrun), 32'h1);

    // Reset during data bit 4.
    rx = 1'b0;
    hold_bit();
    for (int i = 0; i < 4; i++) begin
      rx = 1'(i % 2);
      hold_bit();
    end
    rx = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", 32'(busy), 32'h0);
    check_eq("mid_rst_valid", 32'(data_valid), 32'h0);
    check_eq("mid_rst_overrun", 32'(overrun), 32'h0);
    check_eq("mid_rst_data", 32'(data), 32'h0);
    rx = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    clear_mon();
    send_frame(8'h5A, 1'b0, 1'b1);
    check_eq("5a_count", 32'(acc_cnt), 32'd1);
    check_eq("5a_data", 32'(acc_data), 32'h5A);
    check_eq("5a_perr", 32'(acc_perr), 32'h0);
    check_eq("5a_ferr", 32'(acc_ferr), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/parity_serial_rx.md
Name: parity_serial_rx

Overview:
- Serial frame receiver; the receiving end of the XOR-parity serial link built from the primitive-gate library.
- Frame format: start (0), DATA_W data bits LSB first, one parity bit, stop (1).
- Samples each bit at mid-bit and recomputes parity as an XOR reduction.
- Presents each received word on a single-entry valid/ready output buffer with error flags.

Parameters:
- DATA_W, 8: data bits per frame (1..16).
- CLKS_PER_BIT, 4: clock cycles per serial bit; even, >=4.
- PARITY_ODD, 0: 0 = even parity (XOR of data and parity bit is 0); 1 = odd parity.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx  in  1  serial line, idles high.
- data  out  DATA_W  received word.
- data_valid  out  1  output buffer holds a word.
- data_ready  in  1  consumer accepts the word when high together with data_valid.
- parity_err  out  1  parity mismatch for the word in the buffer.
- frame_err  out  1  stop bit sampled 0 for the word in the buffer.
- overrun  out  1  sticky; a completed frame was dropped because the buffer was full.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async assert, sync release):
  - data=0, data_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
  - FSM to IDLE; bit and cycle counters cleared.
  - Reset mid-frame discards the partial frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - rx=0 sampled -> START, cycle counter=0.
- START:
  - Wait until the counter reaches CLKS_PER_BIT/2-1, then resample rx.
  - rx=1 -> IDLE (false start, nothing reported).
  - rx=0 -> DATA, counter=0, bit index=0.
- DATA:
  - Every CLKS_PER_BIT cycles, sample rx into shift register bit[index]; increment index.
  - After bit DATA_W-1 -> PARITY.
- PARITY:
  - Sample after CLKS_PER_BIT cycles.
  - Mismatch if (^data_bits) ^ parity_bit ^ PARITY_ODD == 1.
- STOP:
  - Sample after CLKS_PER_BIT cycles; rx=0 is a frame error.
  - Next state is always IDLE. rx=0 in that first IDLE cycle starts a new frame only via normal detection.
- Output buffer:
  - The cycle after the stop sample, data, parity_err and frame_err load and data_valid=1, if the buffer is empty or is being accepted that same cycle.
  - Frames containing errors are still delivered, with their flags.
- Handshake:
  - data_valid && data_ready accepts the word; data_valid=0 next cycle unless a new frame loads in the same cycle.
  - data, parity_err and frame_err are stable while data_valid=1 and not accepted.
- Overrun:
  - Frame completes while data_valid=1 and data_ready=0 -> new frame dropped, buffer unchanged, overrun=1.
  - overrun clears only on reset.
- Latency: data_valid rises 1 cycle after the stop-bit sample. The stop bit is sampled about (DATA_W+2)*CLKS_PER_BIT + CLKS_PER_BIT/2 cycles after the start edge is detected.
- busy=1 in START, DATA, PARITY and STOP.
- Counters: cycle counter width $clog2(CLKS_PER_BIT); bit index width $clog2(DATA_W+1); no wrap beyond terminal count.

Optional Feature:
- Macro: PARITY_RX_SYNC_EN.
- Defined:
  - rx passes through a 2-flop synchronizer reset to 1 before the FSM.
  - All rx-to-sample timing shifts by +2 cycles.
  - A 1-cycle rx glitch shorter than the synchronizer delay still behaves as a false start.
- Undefined: rx feeds the FSM directly; the source must be synchronous to clk.

Test Plan (DATA_W=8, CLKS_PER_BIT=4, PARITY_ODD=0, data_ready=1 unless stated):
- Send 0xA5: start, bits 1,0,1,0,0,1,0,1, parity 0, stop 1 -> one data_valid pulse, data=0xA5, parity_err=0, frame_err=0.
- Send 0xA5 with parity bit 1 -> data=0xA5, parity_err=1, frame_err=0. Repeat with PARITY_ODD=1 and parity 1 -> parity_err=0.
- Send 0x3C, parity 0, stop bit 0 -> data=0x3C, frame_err=1. Next valid frame 0x01 (parity 1) is received cleanly.
- rx low for 1 cycle only, then high -> busy pulses, returns to IDLE, no data_valid.
- data_ready=0; send 0x11 then 0x22 -> data=0x11 held, overrun=1. Raise data_ready -> 0x11 accepted, data_valid=0, overrun stays 1.
- Assert rst_n=0 during DATA bit 4 of a frame -> all outputs reset immediately. After release, a full 0x5A frame (parity 0) is received correctly.
